// File: rtl/si_dac_pkg.sv
// Shared types and helpers for the multi-channel serial-input DAC.
package si_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    // Serial frame length: address field followed by data field.
    function automatic int unsigned frame_len(input int unsigned addr_w, input int unsigned width);
        return addr_w + width;
    endfunction

    // Bit counter width: must hold 0..FRAME+1 (FRAME+1 marks an overrun).
    function automatic int unsigned cnt_width(input int unsigned addr_w, input int unsigned width);
        return $clog2(addr_w + width + 2);
    endfunction

    // All-ones channel address selects every channel.
    function automatic int unsigned bcast_addr(input int unsigned addr_w);
        return (1 << addr_w) - 1;
    endfunction

    // Ideal DAC transfer: VREF * code / 2**WIDTH.
    function automatic real code_to_volts(input real vref, input int unsigned code,
                                          input int unsigned width);
        return vref * real'(code) / (2.0 ** width);
    endfunction

endpackage

// File: rtl/si_dac_shift.sv
// Serial frame shift register with saturating bit counter.
module si_dac_shift
    import si_dac_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 shift,
    input  logic                                 clear,
    input  logic                                 si,
    output logic [ADDR_W-1:0]                    addr,
    output logic [WIDTH-1:0]                     data,
    output logic [cnt_width(ADDR_W, WIDTH)-1:0]  count
);

    localparam int unsigned   FRAME   = frame_len(ADDR_W, WIDTH);
    localparam int unsigned   CW      = cnt_width(ADDR_W, WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME + 1);

    logic [FRAME-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Next shift-register contents and bit count.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (start) begin
            sr_d  = {{(FRAME-1){1'b0}}, si};
            cnt_d = CW'(1);
        end else if (shift) begin
            sr_d = {sr_q[FRAME-2:0], si};
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign addr  = sr_q[FRAME-1 -: ADDR_W];
    assign data  = sr_q[WIDTH-1:0];
    assign count = cnt_q;

endmodule

// File: rtl/si_dac_mc.sv
// Multi-channel serial-input DAC: address+data frames shifted in under SI_en,
// committed on soc to per-channel input registers, then to dac_code either
// immediately (MODE=0) or on the update strobe (MODE=1).
// Optional analog monitor output enabled by macro SI_DAC_MC_AOUT_EN.
module si_dac_mc
    import si_dac_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned NCH    = 4,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned MODE   = 0
`ifdef SI_DAC_MC_AOUT_EN
    ,
    parameter real         VREF   = 5.0
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SI,
    input  logic                   SI_en,
    input  logic                   soc,
    input  logic                   update,
`ifdef SI_DAC_MC_AOUT_EN
    input  logic [ADDR_W-1:0]      mon_sel,
    output real                    A_out,
`endif
    output logic [NCH*WIDTH-1:0]   dac_code,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_err
);

    localparam int unsigned       FRAME     = frame_len(ADDR_W, WIDTH);
    localparam int unsigned       CW        = cnt_width(ADDR_W, WIDTH);
    localparam logic [CW-1:0]     FRAME_CNT = CW'(FRAME);
    localparam logic [ADDR_W-1:0] BCAST     = ADDR_W'(bcast_addr(ADDR_W));

    state_e                 state_q, state_d;
    logic [NCH*WIDTH-1:0]   in_q, in_d;
    logic [NCH*WIDTH-1:0]   code_q, code_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   sh_start, sh_shift, sh_clear;
    logic [ADDR_W-1:0]      sh_addr;
    logic [WIDTH-1:0]       sh_data;
    logic [CW-1:0]          sh_count;
    logic                   addr_ok;

    si_dac_shift #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .start (sh_start),
        .shift (sh_shift),
        .clear (sh_clear),
        .si    (SI),
        .addr  (sh_addr),
        .data  (sh_data),
        .count (sh_count)
    );

    assign addr_ok = (32'(sh_addr) < NCH) || (sh_addr == BCAST);

    // Frame FSM, commit check and DAC code update.
    always_comb begin
        state_d  = state_q;
        in_d     = in_q;
        code_d   = code_q;
        done_d   = 1'b0;
        err_d    = err_q;
        sh_start = 1'b0;
        sh_shift = 1'b0;
        sh_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (SI_en) begin
                    sh_start = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (soc) begin
                    err_d    = 1'b1;
                    sh_clear = 1'b1;
                    state_d  = ST_IDLE;
                end else if (SI_en) begin
                    sh_shift = 1'b1;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (soc) begin
                    sh_clear = 1'b1;
                    state_d  = ST_IDLE;
                    if ((sh_count == FRAME_CNT) && addr_ok) begin
                        for (int unsigned k = 0; k < NCH; k++) begin
                            if ((sh_addr == BCAST) || (sh_addr == ADDR_W'(k))) begin
                                in_d[k*WIDTH +: WIDTH] = sh_data;
                            end
                        end
                        done_d = 1'b1;
                        err_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (SI_en) begin
                    sh_start = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Buffered mode copies the pre-commit input registers on update.
        if (MODE == 0) begin
            code_d = in_d;
        end else if (update) begin
            code_d = in_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            in_q    <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            code_q  <= code_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dac_code   = code_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign frame_err  = err_q;

`ifdef SI_DAC_MC_AOUT_EN
    logic [WIDTH-1:0] mon_code;
    logic             mon_hit;

    // Analog model of the monitored channel.
    always_comb begin
        mon_code = '0;
        mon_hit  = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (mon_sel == ADDR_W'(k)) begin
                mon_code = code_q[k*WIDTH +: WIDTH];
                mon_hit  = 1'b1;
            end
        end
        A_out = 0.0;
        if (!rst && mon_hit) begin
            A_out = code_to_volts(VREF, 32'(mon_code), WIDTH);
        end
    end
`endif

endmodule

// File: tb/tb_si_dac_mc.sv
// Self-checking bench for si_dac_mc: one immediate-mode and one buffered-mode
// instance share the same serial stimulus and are checked against a
// frame-level reference model.
module tb_si_dac_mc;

    localparam int unsigned W   = 12;
    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 3;
    localparam int unsigned FRM = AW + W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic SI = 1'b0, SI_en = 1'b0, soc = 1'b0, update = 1'b0;
    logic [N*W-1:0] dac0, dac1;
    logic busy0, busy1, done0, done1, err0, err1;
`ifdef SI_DAC_MC_AOUT_EN
    logic [AW-1:0] mon_sel = '0;
    real a_out0, a_out1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: input registers, dac codes of each instance, error flag
    logic [W-1:0] m_in [N];
    logic [W-1:0] m_d0 [N];
    logic [W-1:0] m_d1 [N];
    logic         m_err;

    always #5 clk = ~clk;

    si_dac_mc #(.WIDTH(W), .NCH(N), .ADDR_W(AW), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .SI(SI), .SI_en(SI_en), .soc(soc), .update(update),
`ifdef SI_DAC_MC_AOUT_EN
        .mon_sel(mon_sel), .A_out(a_out0),
`endif
        .dac_code(dac0), .busy(busy0), .frame_done(done0), .frame_err(err0)
    );

    si_dac_mc #(.WIDTH(W), .NCH(N), .ADDR_W(AW), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .SI(SI), .SI_en(SI_en), .soc(soc), .update(update),
`ifdef SI_DAC_MC_AOUT_EN
        .mon_sel(mon_sel), .A_out(a_out1),
`endif
        .dac_code(dac1), .busy(busy1), .frame_done(done1), .frame_err(err1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            m_in[ch] = '0;
            m_d0[ch] = '0;
            m_d1[ch] = '0;
        end
        m_err = 1'b0;
    endtask

    task automatic check_state(input string tag);
        for (int ch = 0; ch < N; ch++) begin
            chk($sformatf("%s imm ch%0d", tag, ch), dac0[ch*W +: W], m_d0[ch]);
            chk($sformatf("%s buf ch%0d", tag, ch), dac1[ch*W +: W], m_d1[ch]);
        end
        chk({tag, " err imm"}, err0, m_err);
        chk({tag, " err buf"}, err1, m_err);
    endtask

    // Send nbits of a frame (first nbits of {addr,data}, or the frame followed
    // by random extra bits when longer), one ARMED cycle, then soc.
    task automatic send_frame(input string tag, input int unsigned addr,
                              input int unsigned data, input int unsigned nbits,
                              input bit upd);
        logic [31:0] word, stream;
        bit valid;
        word = (addr << W) | (data & ((1 << W) - 1));
        if (nbits <= FRM) stream = word >> (FRM - nbits);
        else stream = (word << (nbits - FRM)) | ($urandom & ((1 << (nbits - FRM)) - 1));
        for (int unsigned i = 0; i < nbits; i++) begin
            SI_en = 1'b1;
            SI    = stream[nbits-1-i];
            tick();
            chk({tag, " busy shift"}, {busy0, busy1}, 2'b11);
        end
        SI_en = 1'b0;
        SI    = 1'b0;
        tick();
        chk({tag, " busy armed"}, {busy0, busy1}, 2'b11);
        soc    = 1'b1;
        update = upd;
        tick();
        soc    = 1'b0;
        update = 1'b0;
        if (upd) m_d1 = m_in;
        valid = (nbits == FRM) && ((addr < N) || (addr == (1 << AW) - 1));
        if (valid) begin
            for (int ch = 0; ch < N; ch++)
                if (addr == (1 << AW) - 1 || addr == ch) m_in[ch] = W'(data);
            m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        m_d0 = m_in;
        chk({tag, " done"}, {done0, done1}, {valid, valid});
        check_state(tag);
        tick();
        chk({tag, " done low"}, {done0, done1}, 2'b00);
        chk({tag, " idle"}, {busy0, busy1}, 2'b00);
    endtask

    task automatic pulse_update(input string tag);
        update = 1'b1;
        tick();
        update = 1'b0;
        m_d1 = m_in;
        check_state(tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_state("reset");
        chk("reset busy/done", {busy0, busy1, done0, done1}, 4'b0000);

        send_frame("ch2 ABC", 2, 12'hABC, FRM, 1'b0);
        send_frame("bcast 800", 7, 12'h800, FRM, 1'b0);
`ifdef SI_DAC_MC_AOUT_EN
        mon_sel = 3'd1;
        #1;
        chk("aout mv", 64'(int'(a_out0 * 1000.0)), 64'd2500);
        mon_sel = 3'd5;
        #1;
        chk("aout oob", 64'(int'(a_out0 * 1000.0)), 64'd0);
`endif
        send_frame("short 14", 0, 12'h111, 14, 1'b0);
        send_frame("long 17", 0, 12'h222, 17, 1'b0);
        send_frame("ch0 FFF", 0, 12'hFFF, FRM, 1'b0);

        send_frame("buf ch1 123", 1, 12'h123, FRM, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state("buf hold");
        end
        pulse_update("buf upd1");
        send_frame("buf soc+upd 456", 1, 12'h456, FRM, 1'b1);
        pulse_update("buf upd2");

        send_frame("addr 5", 5, 12'h555, FRM, 1'b0);

        // soc while still shifting
        for (int i = 0; i < 4; i++) begin
            SI_en = 1'b1;
            SI    = 1'b1;
            tick();
        end
        soc = 1'b1;
        tick();
        soc   = 1'b0;
        SI_en = 1'b0;
        m_err = 1'b1;
        chk("mid soc busy/done", {busy0, busy1, done0, done1}, 4'b0000);
        check_state("mid soc");

        // reset after 7 bits
        for (int i = 0; i < 7; i++) begin
            SI_en = 1'b1;
            SI    = 1'($urandom);
            tick();
        end
        SI_en = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("rst busy", {busy0, busy1}, 2'b00);
        check_state("rst mid");
        send_frame("after rst", 3, 12'h5A5, FRM, 1'b0);

        // randomized frames, updates and idle gaps
        for (int it = 0; it < 40; it++) begin
            int unsigned r, nb;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse_update("rnd upd");
            end else if (r == 1) begin
                repeat ($urandom_range(1, 3)) tick();
                check_state("rnd gap");
            end else begin
                case ($urandom_range(0, 5))
                    0: nb = FRM - 1;
                    1: nb = FRM + 1;
                    2: nb = FRM + 2;
                    default: nb = FRM;
                endcase
                send_frame($sformatf("rnd%0d", it), $urandom_range(0, 7),
                           $urandom_range(0, 4095), nb, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
